adc_ram_writer: RTL and testbench

//  Initiator for the shared RAM's ADC write-only port (adc_wEn/adc_addr/adc_dataIn).

---
 rtl/adc_ram_writer_pkg.sv | 29 ++
 rtl/adc_ring_ptr.sv | 40 ++++
 rtl/adc_ram_writer.sv | 168 ++++++++++++++++
 tb/tb_adc_ram_writer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ram_writer_pkg.sv
// adc_ram_writer_pkg
//   Shared definitions for the ADC-to-RAM capture writer:
//   - FSM state encoding used by adc_ram_writer
//   - configuration consistency checks for the capture window
//   No ports (package).
package adc_ram_writer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Smallest legal capture window.
    localparam int MIN_BUF_DEPTH = 1;

    // True when [base, base+depth-1] lies entirely inside a 2**aw word RAM.
    function automatic bit window_fits(int base, int depth, int aw);
        longint ram_words;
        ram_words = longint'(1) << aw;
        return (depth >= MIN_BUF_DEPTH) && ((longint'(base) + longint'(depth)) <= ram_words);
    endfunction

    // True when a sample zero-extends into a RAM word without truncation.
    function automatic bit sample_fits(int sample_width, int data_width);
        return (sample_width >= 1) && (sample_width <= data_width);
    endfunction

endpackage

// File: rtl/adc_ring_ptr.sv
// adc_ring_ptr
//   Write-offset counter for the capture window. Loads zero on clear,
//   increments on advance and wraps from BUF_DEPTH-1 back to 0.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous, active-high
//   clear    in   load zero (capture start)
//   advance  in   step to the next word
//   ptr      out  current offset, 0..BUF_DEPTH-1
//   wrap     out  combinational pulse: this advance wraps to 0
module adc_ring_ptr #(
    parameter int ADDRESS_WIDTH = 12,
    parameter int BUF_DEPTH     = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     advance,
    output logic [ADDRESS_WIDTH-1:0] ptr,
    output logic                     wrap
);

    localparam logic [ADDRESS_WIDTH-1:0] LAST = ADDRESS_WIDTH'(BUF_DEPTH - 1);

    // Combinational so the FSM can leave CAPTURE on the same edge as the last write.
    assign wrap = advance && (ptr == LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= wrap ? '0 : ptr + 1'b1;
        end
    end

endmodule

// File: rtl/adc_ram_writer.sv
// adc_ram_writer
//   Write-only initiator for the shared RAM's ADC port. Accepts samples on a
//   valid/ready stream and writes them, zero-extended, into the RAM window
//   [BASE_ADDR, BASE_ADDR+BUF_DEPTH-1], either once (single-shot) or as a ring.
//   Optional build macro ADC_RAM_WRITER_DECIM_EN adds a decim input: only the
//   first of every decim+1 accepted samples is written.
// Ports:
//   clk, reset            clock; synchronous active-high reset
//   start, stop           capture control pulses (stop wins when both high)
//   continuous            1 = ring buffer, 0 = single-shot; sampled on start
//   sample_valid/_data    ADC sample stream; sample_ready = state is CAPTURE
//   adc_wEn/addr/dataIn   RAM write port, one cycle after acceptance
//   busy, done            state is CAPTURE / DONE
//   wr_ptr                offset of the next word to write
//   wrapped               sticky: ring wrapped since start
//   dropped               sticky: sample offered while DONE
//   decim                 (ADC_RAM_WRITER_DECIM_EN only) keep 1 of decim+1
module adc_ram_writer
    import adc_ram_writer_pkg::*;
#(
    parameter int                     DATA_WIDTH    = 32,
    parameter int                     ADDRESS_WIDTH = 12,
    parameter int                     SAMPLE_WIDTH  = 12,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR   = 'h800,
    parameter int                     BUF_DEPTH     = 1024
`ifdef ADC_RAM_WRITER_DECIM_EN
    ,
    parameter int                     DECIM_WIDTH   = 8
`endif
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     stop,
    input  logic                     continuous,
    input  logic                     sample_valid,
    input  logic [SAMPLE_WIDTH-1:0]  sample_data,
    output logic                     sample_ready,
    output logic                     adc_wEn,
    output logic [ADDRESS_WIDTH-1:0] adc_addr,
    output logic [DATA_WIDTH-1:0]    adc_dataIn,
    output logic                     busy,
    output logic                     done,
    output logic [ADDRESS_WIDTH-1:0] wr_ptr,
    output logic                     wrapped,
    output logic                     dropped
`ifdef ADC_RAM_WRITER_DECIM_EN
    ,
    input  logic [DECIM_WIDTH-1:0]   decim
`endif
);

    if (!window_fits(int'(BASE_ADDR), BUF_DEPTH, ADDRESS_WIDTH) ||
        !sample_fits(SAMPLE_WIDTH, DATA_WIDTH)) begin : g_bad_cfg
        $error("adc_ram_writer: capture window or sample width does not fit the RAM");
    end

    state_t state_q, state_d;

    logic                     accept;
    logic                     keep;
    logic                     start_cap;
    logic                     wrap;
    logic                     cont_q;
    logic                     wen_q;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    data_q;
    logic                     wrapped_q;
    logic                     dropped_q;

    assign sample_ready = (state_q == ST_CAPTURE);
    assign accept       = sample_valid && sample_ready;
    // A new capture may begin from IDLE or DONE; stop overrides start.
    assign start_cap    = start && !stop && (state_q != ST_CAPTURE);

`ifdef ADC_RAM_WRITER_DECIM_EN
    logic [DECIM_WIDTH-1:0] decim_q;
    logic [DECIM_WIDTH-1:0] phase_q;

    // Phase 0 marks the sample that is written; the rest of the group is accepted and discarded.
    assign keep = accept && (phase_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            decim_q <= '0;
            phase_q <= '0;
        end else if (start_cap) begin
            decim_q <= decim;
            phase_q <= '0;
        end else if (accept) begin
            phase_q <= (phase_q == decim_q) ? '0 : phase_q + 1'b1;
        end
    end
`else
    assign keep = accept;
`endif

    adc_ring_ptr #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .BUF_DEPTH     (BUF_DEPTH)
    ) u_ring_ptr (
        .clk     (clk),
        .reset   (reset),
        .clear   (start_cap),
        .advance (keep),
        .ptr     (wr_ptr),
        .wrap    (wrap)
    );

    // NOTE: every variable assigned here gets a default first, so no path
    // through the case can leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_cap) state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                if (stop)                 state_d = ST_IDLE;
                else if (wrap && !cont_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (stop)           state_d = ST_IDLE;
                else if (start_cap) state_d = ST_CAPTURE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cont_q    <= 1'b0;
            wen_q     <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            wrapped_q <= 1'b0;
            dropped_q <= 1'b0;
        end else begin
            state_q <= state_d;
            // The write stage is independent of the next state: a sample
            // accepted on the same edge as stop or the last word still lands.
            wen_q   <= keep;
            if (keep) begin
                addr_q <= BASE_ADDR + wr_ptr;
                data_q <= DATA_WIDTH'(sample_data);
            end
            if (start_cap) cont_q <= continuous;

            if (start_cap)          wrapped_q <= 1'b0;
            else if (wrap && cont_q) wrapped_q <= 1'b1;

            if (start_cap)                                 dropped_q <= 1'b0;
            else if (state_q == ST_DONE && sample_valid)   dropped_q <= 1'b1;
        end
    end

    // Masking with reset discards a write still pending when reset arrives,
    // so the RAM never sees a write in a reset cycle.
    assign adc_wEn    = wen_q && !reset;
    assign adc_addr   = addr_q;
    assign adc_dataIn = data_q;
    assign busy       = (state_q == ST_CAPTURE);
    assign done       = (state_q == ST_DONE);
    assign wrapped    = wrapped_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_adc_ram_writer.sv
// tb_adc_ram_writer
//   Self-checking bench for adc_ram_writer with BUF_DEPTH=4 at BASE_ADDR 0x800.
//   Holds a RAM model whose write port is driven by the DUT and whose
//   combinational vga read port is used to check stored words.
//   Build with ADC_RAM_WRITER_DECIM_EN defined to also exercise decimation.
module tb_adc_ram_writer;

    localparam int DW    = 32;
    localparam int AW    = 12;
    localparam int SW    = 12;
    localparam int DEPTH = 4;

    typedef struct {
        logic          rst;
        logic          start;
        logic          stop;
        logic          cont;
        logic          valid;
        logic [SW-1:0] data;
        logic          e_ready;
        logic          e_wen;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_din;
        logic          e_busy;
        logic          e_done;
        logic [AW-1:0] e_ptr;
        logic          e_wrapped;
        logic          e_dropped;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          continuous = 1'b0;
    logic          sample_valid = 1'b0;
    logic [SW-1:0] sample_data = '0;
    logic          sample_ready;
    logic          adc_wEn;
    logic [AW-1:0] adc_addr;
    logic [DW-1:0] adc_dataIn;
    logic          busy;
    logic          done;
    logic [AW-1:0] wr_ptr;
    logic          wrapped;
    logic          dropped;
`ifdef ADC_RAM_WRITER_DECIM_EN
    logic [7:0]    decim = '0;
`endif

    int tests  = 0;
    int failed = 0;

    vec_t vecs[$];

    // RAM model. NOTE: memory arrays are never reset; only their control path is.
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic [AW-1:0] vga_addr = '0;
    logic [DW-1:0] vga_data;

    always @(posedge clk) begin
        if (adc_wEn) ram[adc_addr] <= adc_dataIn;
    end
    assign vga_data = ram[vga_addr];

    always #5 clk = ~clk;

    adc_ram_writer #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .SAMPLE_WIDTH  (SW),
        .BASE_ADDR     (12'h800),
        .BUF_DEPTH     (DEPTH)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .stop         (stop),
        .continuous   (continuous),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .adc_wEn      (adc_wEn),
        .adc_addr     (adc_addr),
        .adc_dataIn   (adc_dataIn),
        .busy         (busy),
        .done         (done),
        .wr_ptr       (wr_ptr),
        .wrapped      (wrapped),
        .dropped      (dropped)
`ifdef ADC_RAM_WRITER_DECIM_EN
        ,
        .decim        (decim)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_ram(input string name, input logic [AW-1:0] a, input logic [DW-1:0] e);
        vga_addr = a;
        #1;
        check(name, 64'(vga_data), 64'(e));
    endtask

    function automatic vec_t v(input logic rst, st, sp, ct, vl, input logic [SW-1:0] d,
                               input logic rdy, wen, input logic [AW-1:0] a,
                               input logic [DW-1:0] di, input logic bsy, dn,
                               input logic [AW-1:0] p, input logic wr, dr);
        vec_t r;
        r.rst = rst; r.start = st; r.stop = sp; r.cont = ct; r.valid = vl; r.data = d;
        r.e_ready = rdy; r.e_wen = wen; r.e_addr = a; r.e_din = di;
        r.e_busy = bsy; r.e_done = dn; r.e_ptr = p; r.e_wrapped = wr; r.e_dropped = dr;
        return r;
    endfunction

    // Address/data are only meaningful while the write enable is high.
    function automatic logic [63:0] pack(input logic rdy, wen, input logic [AW-1:0] a,
                                         input logic [DW-1:0] di, input logic bsy, dn,
                                         input logic [AW-1:0] p, input logic wr, dr);
        return {2'b00, rdy, wen, (wen ? a : '0), (wen ? di : '0), bsy, dn, p, wr, dr};
    endfunction

    // Each row drives inputs for one cycle and checks outputs just after the edge.
    task automatic run_vecs(input string phase);
        foreach (vecs[i]) begin
            @(negedge clk);
            reset        = vecs[i].rst;
            start        = vecs[i].start;
            stop         = vecs[i].stop;
            continuous   = vecs[i].cont;
            sample_valid = vecs[i].valid;
            sample_data  = vecs[i].data;
            @(posedge clk);
            #1;
            check($sformatf("%s row %0d", phase, i),
                  pack(sample_ready, adc_wEn, adc_addr, adc_dataIn, busy, done, wr_ptr, wrapped, dropped),
                  pack(vecs[i].e_ready, vecs[i].e_wen, vecs[i].e_addr, vecs[i].e_din,
                       vecs[i].e_busy, vecs[i].e_done, vecs[i].e_ptr, vecs[i].e_wrapped,
                       vecs[i].e_dropped));
        end
        vecs.delete();
    endtask

    initial begin
        // 1: single-shot fill of the 4-word window.
        vecs.push_back(v(1,0,0,0,0,12'h0,  0,0,12'h000,32'h0,  0,0,12'd0,0,0));
        vecs.push_back(v(0,1,0,0,0,12'h0,  1,0,12'h000,32'h0,  1,0,12'd0,0,0));
        vecs.push_back(v(0,0,0,0,1,12'h1,  1,1,12'h800,32'h1,  1,0,12'd1,0,0));
        vecs.push_back(v(0,0,0,0,1,12'h2,  1,1,12'h801,32'h2,  1,0,12'd2,0,0));
        vecs.push_back(v(0,0,0,0,1,12'h3,  1,1,12'h802,32'h3,  1,0,12'd3,0,0));
        vecs.push_back(v(0,0,0,0,1,12'h4,  0,1,12'h803,32'h4,  0,1,12'd0,0,0));
        vecs.push_back(v(0,0,0,0,0,12'h0,  0,0,12'h000,32'h0,  0,1,12'd0,0,0));
        run_vecs("single");
        check_ram("single ram 800", 12'h800, 32'd1);
        check_ram("single ram 801", 12'h801, 32'd2);
        check_ram("single ram 802", 12'h802, 32'd3);
        check_ram("single ram 803", 12'h803, 32'd4);

        // 2: ring capture; continuous input drops back to 0 after start.
        vecs.push_back(v(0,1,0,1,0,12'd0,  1,0,12'h000,32'd0,  1,0,12'd0,0,0));
        vecs.push_back(v(0,0,0,0,1,12'd10, 1,1,12'h800,32'd10, 1,0,12'd1,0,0));
        vecs.push_back(v(0,0,0,0,1,12'd11, 1,1,12'h801,32'd11, 1,0,12'd2,0,0));
        vecs.push_back(v(0,0,0,0,1,12'd12, 1,1,12'h802,32'd12, 1,0,12'd3,0,0));
        vecs.push_back(v(0,0,0,0,1,12'd13, 1,1,12'h803,32'd13, 1,0,12'd0,1,0));
        vecs.push_back(v(0,0,0,0,1,12'd14, 1,1,12'h800,32'd14, 1,0,12'd1,1,0));
        vecs.push_back(v(0,0,0,0,1,12'd15, 1,1,12'h801,32'd15, 1,0,12'd2,1,0));
        vecs.push_back(v(0,0,0,0,0,12'd0,  1,0,12'h000,32'd0,  1,0,12'd2,1,0));
        run_vecs("ring");
        check_ram("ring ram 800", 12'h800, 32'd14);
        check_ram("ring ram 801", 12'h801, 32'd15);
        check_ram("ring ram 802", 12'h802, 32'd12);
        check_ram("ring ram 803", 12'h803, 32'd13);

        // 3: stop coincides with the third acceptance.
        vecs.push_back(v(0,0,1,0,0,12'h0,  0,0,12'h000,32'h0,  0,0,12'd2,1,0));
        vecs.push_back(v(0,1,0,0,0,12'h0,  1,0,12'h000,32'h0,  1,0,12'd0,0,0));
        vecs.push_back(v(0,0,0,0,1,12'h21, 1,1,12'h800,32'h21, 1,0,12'd1,0,0));
        vecs.push_back(v(0,0,0,0,1,12'h22, 1,1,12'h801,32'h22, 1,0,12'd2,0,0));
        vecs.push_back(v(0,0,1,0,1,12'h23, 0,1,12'h802,32'h23, 0,0,12'd3,0,0));
        vecs.push_back(v(0,0,0,0,1,12'h24, 0,0,12'h000,32'h0,  0,0,12'd3,0,0));
        run_vecs("stop");
        check_ram("stop ram 802", 12'h802, 32'h23);
        check_ram("stop ram 803", 12'h803, 32'd13);

        // 4: start&stop in IDLE, dropped in DONE, start ignored in CAPTURE.
        vecs.push_back(v(0,1,1,0,0,12'h0,  0,0,12'h000,32'h0,  0,0,12'd3,0,0));
        vecs.push_back(v(0,1,0,0,0,12'h0,  1,0,12'h000,32'h0,  1,0,12'd0,0,0));
        vecs.push_back(v(0,0,0,0,1,12'h31, 1,1,12'h800,32'h31, 1,0,12'd1,0,0));
        vecs.push_back(v(0,0,0,0,1,12'h32, 1,1,12'h801,32'h32, 1,0,12'd2,0,0));
        vecs.push_back(v(0,0,0,0,1,12'h33, 1,1,12'h802,32'h33, 1,0,12'd3,0,0));
        vecs.push_back(v(0,0,0,0,1,12'h34, 0,1,12'h803,32'h34, 0,1,12'd0,0,0));
        vecs.push_back(v(0,0,0,0,1,12'h35, 0,0,12'h000,32'h0,  0,1,12'd0,0,1));
        vecs.push_back(v(0,0,0,0,0,12'h0,  0,0,12'h000,32'h0,  0,1,12'd0,0,1));
        vecs.push_back(v(0,1,0,0,0,12'h0,  1,0,12'h000,32'h0,  1,0,12'd0,0,0));
        vecs.push_back(v(0,1,0,1,1,12'h36, 1,1,12'h800,32'h36, 1,0,12'd1,0,0));
        run_vecs("flags");
        check_ram("flags ram 803", 12'h803, 32'h34);

        // 5: reset in the cycle after an acceptance discards the pending write.
        @(negedge clk);
        start        = 1'b0;
        continuous   = 1'b0;
        sample_valid = 1'b1;
        sample_data  = 12'h41;
        @(posedge clk);
        #1;
        reset        = 1'b1;
        sample_valid = 1'b0;
        #1;
        check("reset masks wEn", 64'(adc_wEn), 64'd0);
        check("reset pre-edge ptr", 64'(wr_ptr), 64'd2);
        @(posedge clk);
        #1;
        check("reset outputs",
              {2'b00, sample_ready, adc_wEn, adc_addr, adc_dataIn, busy, done, wr_ptr, wrapped, dropped},
              64'd0);
        @(negedge clk);
        reset = 1'b0;
        check_ram("reset ram 801", 12'h801, 32'h32);
        check_ram("reset ram 800", 12'h800, 32'h36);

`ifdef ADC_RAM_WRITER_DECIM_EN
        // 6: decim=2 keeps samples 0, 3, 6.
        @(negedge clk);
        start = 1'b1;
        decim = 8'd2;
        @(negedge clk);
        start = 1'b0;
        decim = 8'd0;
        for (int k = 0; k < 9; k++) begin
            sample_valid = 1'b1;
            sample_data  = SW'(k);
            @(negedge clk);
        end
        sample_valid = 1'b0;
        @(negedge clk);
        check("decim ptr", 64'(wr_ptr), 64'd3);
        check("decim busy", 64'(busy), 64'd1);
        check_ram("decim ram 800", 12'h800, 32'd0);
        check_ram("decim ram 801", 12'h801, 32'd3);
        check_ram("decim ram 802", 12'h802, 32'd6);
        check_ram("decim ram 803", 12'h803, 32'h34);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
